if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 16-bit, eight-register MIPS pipeline. The block owns the program counter, drives the synchronous-read instruction memory, and presents one instruction per cycle to decode. It obeys the hazard unit's `pc_en`/`ifid_en` stall enables and the EX-stage branch redirect. A one-entry skid register keeps an instruction that returns from memory during a stall, so none is lost.

---
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the program counter and drives a synchronous-read instruction memory.
// Presents one instruction per cycle to decode.
// A one-entry skid register keeps the word that returns from memory while
// decode is stalled, so that word is not lost.
module if_stage #(
    parameter int PC_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_en,
    input  logic               ifid_en,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc1,
    output logic               ifid_valid
);

    localparam logic [PC_W-1:0]    PC_ZERO = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]    PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [INSTR_W-1:0] NOP     = {INSTR_W{1'b0}};

    // Action taken on the coming edge when reset is not asserted.
    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_STALL   = 2'd1,
        ACT_ADVANCE = 2'd2
    } act_e;

    logic               stall_s;
    act_e               act_s;

    logic [PC_W-1:0]    pc_r,         pc_nxt_s;
    logic               req_valid_r,  req_valid_nxt_s;
    logic [PC_W-1:0]    req_pc_r,     req_pc_nxt_s;
    logic               hold_valid_r, hold_valid_nxt_s;
    logic [INSTR_W-1:0] hold_instr_r, hold_instr_nxt_s;
    logic [PC_W-1:0]    hold_pc_r,    hold_pc_nxt_s;
    logic [INSTR_W-1:0] ifid_instr_r, ifid_instr_nxt_s;
    logic [PC_W-1:0]    ifid_pc_r,    ifid_pc_nxt_s;
    logic [PC_W-1:0]    ifid_pc1_r,   ifid_pc1_nxt_s;
    logic               ifid_valid_r, ifid_valid_nxt_s;

    // Either hazard enable being low freezes the whole front end.
    assign stall_s   = ~pc_en | ~ifid_en;
    // A request goes out only when the current pc will actually be consumed.
    assign imem_req  = ~rst & ~branch_taken & ~stall_s;
    assign imem_addr = pc_r;

    assign ifid_instr = ifid_instr_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_pc1   = ifid_pc1_r;
    assign ifid_valid = ifid_valid_r;

    // Select the edge action: a redirect beats a stall, which beats an advance.
    always_comb begin
        act_s = ACT_ADVANCE;
        if (branch_taken) begin
            act_s = ACT_FLUSH;
        end else if (stall_s) begin
            act_s = ACT_STALL;
        end else begin
            act_s = ACT_ADVANCE;
        end
    end

    // Next-state logic for the pc, the in-flight fetch, the skid entry and IF/ID.
    always_comb begin
        pc_nxt_s         = pc_r;
        req_valid_nxt_s  = req_valid_r;
        req_pc_nxt_s     = req_pc_r;
        hold_valid_nxt_s = hold_valid_r;
        hold_instr_nxt_s = hold_instr_r;
        hold_pc_nxt_s    = hold_pc_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_pc_nxt_s    = ifid_pc_r;
        ifid_pc1_nxt_s   = ifid_pc1_r;
        ifid_valid_nxt_s = ifid_valid_r;
        case (act_s)
            ACT_FLUSH: begin
                // Wrong-path data in flight or in the skid entry is dropped.
                pc_nxt_s         = branch_target;
                req_valid_nxt_s  = 1'b0;
                hold_valid_nxt_s = 1'b0;
                ifid_valid_nxt_s = 1'b0;
                ifid_instr_nxt_s = NOP;
            end
            ACT_STALL: begin
                // Catch the returning word now, since rdata is only valid this one cycle.
                if (req_valid_r && !hold_valid_r) begin
                    hold_valid_nxt_s = 1'b1;
                    hold_instr_nxt_s = imem_rdata;
                    hold_pc_nxt_s    = req_pc_r;
                end else begin
                    hold_valid_nxt_s = hold_valid_r;
                end
                req_valid_nxt_s = 1'b0;
            end
            ACT_ADVANCE: begin
                // The skid entry is older than anything in flight, so it goes first.
                if (hold_valid_r) begin
                    ifid_instr_nxt_s = hold_instr_r;
                    ifid_pc_nxt_s    = hold_pc_r;
                    ifid_pc1_nxt_s   = hold_pc_r + PC_ONE;
                    ifid_valid_nxt_s = 1'b1;
                end else if (req_valid_r) begin
                    ifid_instr_nxt_s = imem_rdata;
                    ifid_pc_nxt_s    = req_pc_r;
                    ifid_pc1_nxt_s   = req_pc_r + PC_ONE;
                    ifid_valid_nxt_s = 1'b1;
                end else begin
                    ifid_instr_nxt_s = NOP;
                    ifid_valid_nxt_s = 1'b0;
                end
                hold_valid_nxt_s = 1'b0;
                req_valid_nxt_s  = 1'b1;
                req_pc_nxt_s     = pc_r;
                pc_nxt_s         = pc_r + PC_ONE;
            end
            default: begin
                pc_nxt_s         = pc_r;
                req_valid_nxt_s  = 1'b0;
                hold_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset wins over flush and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            req_valid_r  <= 1'b0;
            req_pc_r     <= PC_ZERO;
            hold_valid_r <= 1'b0;
            hold_instr_r <= NOP;
            hold_pc_r    <= PC_ZERO;
            ifid_instr_r <= NOP;
            ifid_pc_r    <= PC_ZERO;
            ifid_pc1_r   <= PC_ONE;
            ifid_valid_r <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            req_valid_r  <= req_valid_nxt_s;
            req_pc_r     <= req_pc_nxt_s;
            hold_valid_r <= hold_valid_nxt_s;
            hold_instr_r <= hold_instr_nxt_s;
            hold_pc_r    <= hold_pc_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_pc_r    <= ifid_pc_nxt_s;
            ifid_pc1_r   <= ifid_pc1_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage.
// Expected IF/ID contents are queued when each step is driven.
// They are popped and compared one edge later.
module tb_if_stage;

    typedef struct packed {
        logic        v;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc1;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        pc_en;
    logic        ifid_en;
    logic        branch_taken;
    logic [15:0] branch_target;

    logic        imem_req_a, imem_req_b;
    logic [15:0] imem_addr_a, imem_addr_b;
    logic [15:0] imem_rdata_a, imem_rdata_b;
    logic [15:0] ifid_instr_a, ifid_instr_b;
    logic [15:0] ifid_pc_a, ifid_pc_b;
    logic [15:0] ifid_pc1_a, ifid_pc1_b;
    logic        ifid_valid_a, ifid_valid_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t last_exp;
    logic chk_b;
    int   n_run;
    int   n_fail;

    if_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .pc_en(pc_en), .ifid_en(ifid_en),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
        .ifid_instr(ifid_instr_a), .ifid_pc(ifid_pc_a), .ifid_pc1(ifid_pc1_a),
        .ifid_valid(ifid_valid_a)
    );

    if_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst), .pc_en(pc_en), .ifid_en(ifid_en),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .ifid_instr(ifid_instr_b), .ifid_pc(ifid_pc_b), .ifid_pc1(ifid_pc1_b),
        .ifid_valid(ifid_valid_b)
    );

    // Memory contents: mem[i] = 0x1000 + i, modulo 2^16.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories that latch an address only when requested.
    always @(posedge clk) begin
        if (imem_req_a) imem_rdata_a <= mem_word(imem_addr_a);
        if (imem_req_b) imem_rdata_b <= mem_word(imem_addr_b);
    end

    task automatic push_exp(input exp_t e);
        q_a.push_back(e);
        last_exp = e;
    endtask

    task automatic exp_fetch(input logic [15:0] a);
        exp_t e;
        e = {1'b1, mem_word(a), a, a + 16'd1};
        push_exp(e);
    endtask

    task automatic exp_bubble();
        exp_t e;
        e = {1'b0, 16'h0000, last_exp.pc, last_exp.pc1};
        push_exp(e);
    endtask

    task automatic exp_hold();
        push_exp(last_exp);
    endtask

    task automatic exp_reset();
        exp_t e;
        e = {1'b0, 16'h0000, 16'h0000, 16'h0001};
        push_exp(e);
    endtask

    task automatic check_req(input logic exp_req, input logic [15:0] exp_addr, input string tag);
        n_run++;
        assert ({imem_req_a, imem_addr_a} === {exp_req, exp_addr}) else begin
            n_fail++;
            $error("FAIL %s: req/addr got %0b/%h want %0b/%h", tag, imem_req_a, imem_addr_a, exp_req, exp_addr);
        end
    endtask

    task automatic tick(input string tag);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        n_run++;
        assert (q_a.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: scoreboard empty got 0 entries want 1", tag);
        end
        if (q_a.size() != 0) begin
            e   = q_a.pop_front();
            got = {ifid_valid_a, ifid_instr_a, ifid_pc_a, ifid_pc1_a};
            n_run++;
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s: v/instr/pc/pc1 got %0b/%h/%h/%h want %0b/%h/%h/%h", tag,
                       got.v, got.instr, got.pc, got.pc1, e.v, e.instr, e.pc, e.pc1);
            end
        end
        if (chk_b && q_b.size() != 0) begin
            e   = q_b.pop_front();
            got = {ifid_valid_b, ifid_instr_b, ifid_pc_b, ifid_pc1_b};
            n_run++;
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s_wrap: v/instr/pc/pc1 got %0b/%h/%h/%h want %0b/%h/%h/%h", tag,
                       got.v, got.instr, got.pc, got.pc1, e.v, e.instr, e.pc, e.pc1);
            end
        end
    endtask

    // Directed sequence: reset, free run, stall, flush, flush-in-stall, reset-in-stall.
    initial begin
        n_run = 0;
        n_fail = 0;
        chk_b = 1'b1;
        rst = 1'b1;
        pc_en = 1'b1;
        ifid_en = 1'b1;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        last_exp = '0;

        // Reset state on both instances.
        exp_reset(); q_b.push_back({1'b0, 16'h0000, 16'h0000, 16'h0001});
        tick("reset0");
        exp_reset(); q_b.push_back({1'b0, 16'h0000, 16'h0000, 16'h0001});
        tick("reset1");

        // Cycle before E0 issues RESET_PC.
        rst = 1'b0;
        #1;
        check_req(1'b1, 16'h0000, "req_e0");
        n_run++;
        assert (imem_addr_b === 16'hFFFE) else begin
            n_fail++;
            $error("FAIL addr_wrap_e0: got %h want %h", imem_addr_b, 16'hFFFE);
        end
        exp_bubble(); q_b.push_back({1'b0, 16'h0000, 16'h0000, 16'h0001});
        tick("e0_bubble");

        // Free run; the wrap instance crosses 0xFFFF -> 0x0000.
        q_b.push_back({1'b1, 16'h0FFE, 16'hFFFE, 16'hFFFF});
        q_b.push_back({1'b1, 16'h0FFF, 16'hFFFF, 16'h0000});
        q_b.push_back({1'b1, 16'h1000, 16'h0000, 16'h0001});
        q_b.push_back({1'b1, 16'h1001, 16'h0001, 16'h0002});
        for (int a = 0; a < 4; a++) begin
            exp_fetch(16'(a));
            tick("free_run");
        end
        chk_b = 1'b0;
        exp_fetch(16'h0004);
        tick("free_run4");

        // Stall 3 cycles with 0x0005 in flight, using each enable alone too.
        pc_en = 1'b0; ifid_en = 1'b0;
        #1;
        check_req(1'b0, 16'h0006, "req_stall");
        exp_hold(); tick("stall_both");
        pc_en = 1'b0; ifid_en = 1'b1;
        exp_hold(); tick("stall_pc_en");
        pc_en = 1'b1; ifid_en = 1'b0;
        #1;
        check_req(1'b0, 16'h0006, "req_stall_ifid");
        exp_hold(); tick("stall_ifid_en");
        ifid_en = 1'b1;
        #1;
        check_req(1'b1, 16'h0006, "req_resume");
        exp_fetch(16'h0005); tick("resume_skid");
        exp_fetch(16'h0006); tick("resume_next");
        exp_fetch(16'h0007); tick("resume_next2");
        for (int a = 8; a < 16; a++) begin
            exp_fetch(16'(a));
            tick("run_to_10");
        end

        // Redirect to 0x0040 while 0x0010 is in flight.
        branch_taken = 1'b1; branch_target = 16'h0040;
        #1;
        check_req(1'b0, 16'h0011, "req_branch");
        exp_bubble(); tick("flush_b1");
        branch_taken = 1'b0;
        #1;
        check_req(1'b1, 16'h0040, "req_target");
        exp_bubble(); tick("flush_b2");
        exp_fetch(16'h0040); tick("target");
        exp_fetch(16'h0041); tick("target_next");

        // Flush during a stall whose skid entry holds 0x0042.
        pc_en = 1'b0;
        exp_hold(); tick("skid_fill");
        exp_hold(); tick("skid_keep");
        branch_taken = 1'b1; branch_target = 16'h0040;
        exp_bubble(); tick("flush_in_stall");
        branch_taken = 1'b0;
        #1;
        check_req(1'b0, 16'h0040, "req_stalled_target");
        exp_hold(); tick("stall_after_flush");
        pc_en = 1'b1;
        #1;
        check_req(1'b1, 16'h0040, "req_release");
        exp_bubble(); tick("release_bubble");
        exp_fetch(16'h0040); tick("target_after_stall");
        exp_fetch(16'h0041); tick("target_after_stall_next");

        // Reset in the second cycle of a stall.
        ifid_en = 1'b0;
        exp_hold(); tick("stall_pre_reset");
        rst = 1'b1;
        exp_reset(); tick("reset_mid_stall");
        rst = 1'b0; ifid_en = 1'b1;
        #1;
        check_req(1'b1, 16'h0000, "req_after_reset");
        exp_bubble(); tick("post_reset_bubble");
        for (int a = 0; a < 3; a++) begin
            exp_fetch(16'(a));
            tick("post_reset_run");
        end

        n_run++;
        assert (q_a.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: got %0d entries want 0", q_a.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
